// File: rtl/npc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// npc_fetch_ctrl
//
// Purpose:
//   Fetch-side next-PC controller. Owns the PC register and the IF/ID
//   pipeline register. Each cycle the instruction in ID is resolved against
//   the comparator flags from the ID stage. The controller then either
//   holds (stall) or advances with the selected next PC. The candidate
//   next PCs are sequential, conditional branch, J/JAL and JR/JALR.
//   MIPS delay-slot semantics apply: nothing is flushed, and the
//   instruction after a control transfer always executes.
//
// Parameters:
//   PC_RESET  PC value loaded on reset
//   CNT_W     width of the saturating taken-redirect counter
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   stall        hold PC, IF/ID and counter this cycle
//   if_instr     instruction word fetched from IM at address pc
//   br_type      ID control: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz,
//                5 bltz, 6 bgez, 7 j, 8 jal, 9 jr, 10 jalr, 11-15 none
//   validbeq..validbgez  comparator flags for the ID instruction
//   jr_target    forwarded rs value for jr/jalr
//   pc           current fetch address
//   id_instr     IF/ID instruction register
//   id_pc        PC of the instruction in ID
//   id_pc8       id_pc + 8 (link value)
//   taken        combinational: ID control transfer redirects next PC
//   taken_cnt    number of committed redirects, saturating at all-ones
// ---------------------------------------------------------------------------
module npc_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      if_instr,
    input  logic [3:0]       br_type,
    input  logic             validbeq,
    input  logic             validbne,
    input  logic             validblez,
    input  logic             validbgtz,
    input  logic             validbltz,
    input  logic             validbgez,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc8,
    output logic             taken,
    output logic [CNT_W-1:0] taken_cnt
);

    logic [31:0]      r_pc;
    logic [31:0]      r_id_instr;
    logic [31:0]      r_id_pc;
    logic [CNT_W-1:0] r_taken_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_id_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic        w_cnt_sat;

    // Target computation; all adds wrap modulo 2^32.
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_id_pc_plus4 = r_id_pc + 32'd4;
    // Sign-extended halfword offset, already scaled by 4.
    assign w_br_off      = {{14{r_id_instr[15]}}, r_id_instr[15:0], 2'b00};
    assign w_br_tgt      = w_id_pc_plus4 + w_br_off;
    // The region bits come from the delay-slot address, not the jump itself.
    assign w_j_tgt       = {w_id_pc_plus4[31:28], r_id_instr[25:0], 2'b00};

    always_comb begin
        w_taken   = 1'b0;
        w_next_pc = w_pc_plus4;
        case (br_type)
            4'd1: w_taken = validbeq;
            4'd2: w_taken = validbne;
            4'd3: w_taken = validblez;
            4'd4: w_taken = validbgtz;
            4'd5: w_taken = validbltz;
            4'd6: w_taken = validbgez;
            4'd7,
            4'd8,
            4'd9,
            4'd10: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase

        case (br_type)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                if (w_taken) begin
                    w_next_pc = w_br_tgt;
                end
            end
            4'd7, 4'd8: w_next_pc = w_j_tgt;
            // jr_target passes through untouched; alignment is not enforced here.
            4'd9, 4'd10: w_next_pc = jr_target;
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    assign w_cnt_sat = &r_taken_cnt;

    // Under stall everything holds, so the ID instruction is re-resolved
    // next cycle. A stalled redirect is therefore applied and counted once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= PC_RESET;
            r_id_instr  <= 32'h0000_0000;
            r_id_pc     <= PC_RESET;
            r_taken_cnt <= '0;
        end else if (!stall) begin
            r_pc       <= w_next_pc;
            r_id_instr <= if_instr;
            r_id_pc    <= r_pc;
            if (w_taken && !w_cnt_sat) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign pc        = r_pc;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_pc8    = r_id_pc + 32'd8;
    assign taken     = w_taken;
    assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_npc_fetch_ctrl
//
// Directed bench for npc_fetch_ctrl. A second instance with a 3-bit counter
// shares every input so that counter saturation is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_npc_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] if_instr;
    logic [3:0]  br_type;
    logic        validbeq, validbne, validblez, validbgtz, validbltz, validbgez;
    logic [31:0] jr_target;

    logic [31:0] pc, id_instr, id_pc, id_pc8;
    logic        taken;
    logic [15:0] taken_cnt;

    logic [31:0] s_pc, s_id_instr, s_id_pc, s_id_pc8;
    logic        s_taken;
    logic [2:0]  s_taken_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    npc_fetch_ctrl #(.PC_RESET(32'h0000_3000), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .if_instr(if_instr),
        .br_type(br_type), .validbeq(validbeq), .validbne(validbne),
        .validblez(validblez), .validbgtz(validbgtz), .validbltz(validbltz),
        .validbgez(validbgez), .jr_target(jr_target),
        .pc(pc), .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8),
        .taken(taken), .taken_cnt(taken_cnt)
    );

    npc_fetch_ctrl #(.PC_RESET(32'h0000_3000), .CNT_W(3)) u_dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .if_instr(if_instr),
        .br_type(br_type), .validbeq(validbeq), .validbne(validbne),
        .validblez(validblez), .validbgtz(validbgtz), .validbltz(validbltz),
        .validbgez(validbgez), .jr_target(jr_target),
        .pc(s_pc), .id_instr(s_id_instr), .id_pc(s_id_pc), .id_pc8(s_id_pc8),
        .taken(s_taken), .taken_cnt(s_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, obs);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_flags();
        validbeq = 0; validbne = 0; validblez = 0;
        validbgtz = 0; validbltz = 0; validbgez = 0;
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        if_instr  = 32'h0;
        br_type   = 4'd0;
        jr_target = 32'h0;
        clr_flags();

        #12 reset = 1'b0;
        #1;
        chk("rst_pc",       pc,        32'h0000_3000);
        chk("rst_id_instr", id_instr,  32'h0);
        chk("rst_id_pc",    id_pc,     32'h0000_3000);
        chk("rst_cnt",      {16'h0, taken_cnt}, 32'h0);
        chk("rst_taken",    {31'h0, taken}, 32'h0);

        // Sequential fetch
        if_instr = 32'h1111_3000; step();
        chk("seq1_pc",    pc,    32'h0000_3004);
        chk("seq1_id_pc", id_pc, 32'h0000_3000);
        chk("seq1_instr", id_instr, 32'h1111_3000);
        if_instr = 32'h1111_3004; step();
        chk("seq2_pc",    pc,    32'h0000_3008);
        chk("seq2_id_pc", id_pc, 32'h0000_3004);
        if_instr = 32'h1111_3008; step();
        chk("seq3_pc",    pc,    32'h0000_300C);
        chk("seq3_id_pc", id_pc, 32'h0000_3008);
        chk("seq3_cnt",   {16'h0, taken_cnt}, 32'h0);
        if_instr = 32'h1111_300C; step();
        // beq with offset -4 words fetched from 0x3010
        if_instr = 32'h1000_FFFC; step();
        chk("beq_id_pc", id_pc, 32'h0000_3010);
        br_type = 4'd1; validbeq = 1; if_instr = 32'hDEAD_3014; #1;
        chk("beq_taken",  {31'h0, taken}, 32'h1);
        chk("beq_id_pc8", id_pc8, 32'h0000_3018);
        step();
        chk("beq_pc",    pc,       32'h0000_3004);
        chk("beq_slot",  id_instr, 32'hDEAD_3014);
        chk("beq_slot_pc", id_pc,  32'h0000_3014);
        chk("beq_cnt",   {16'h0, taken_cnt}, 32'h1);

        // beq not taken; the bne flag is set to catch a wrong flag select
        br_type = 4'd0; clr_flags(); if_instr = 32'h1000_FFFC; step();
        br_type = 4'd1; validbne = 1; if_instr = 32'h1400_0002; #1;
        chk("beqnt_taken", {31'h0, taken}, 32'h0);
        step();
        chk("beqnt_pc",  pc, 32'h0000_300C);
        chk("beqnt_cnt", {16'h0, taken_cnt}, 32'h1);

        // bne taken, +2 words from 0x3008: 0x300C + 8
        br_type = 4'd2; clr_flags(); validbne = 1; validbeq = 1; if_instr = 32'h0; #1;
        chk("bne_taken", {31'h0, taken}, 32'h1);
        step();
        chk("bne_pc",  pc, 32'h0000_3014);
        chk("bne_cnt", {16'h0, taken_cnt}, 32'h2);

        // Walk to 0x3020 and place a jal there
        br_type = 4'd0; clr_flags();
        step(); step();
        chk("walk_pc", pc, 32'h0000_301C);
        step();
        if_instr = 32'h0C00_0C40; step();
        chk("jal_id_pc", id_pc, 32'h0000_3020);
        br_type = 4'd8; if_instr = 32'h0; #1;
        chk("jal_taken", {31'h0, taken}, 32'h1);
        chk("jal_pc8",   id_pc8, 32'h0000_3028);
        step();
        chk("jal_pc",  pc, 32'h0000_3100);
        chk("jal_cnt", {16'h0, taken_cnt}, 32'h3);

        // jr under a two-cycle stall, target changes on the last stall cycle
        br_type = 4'd0; if_instr = 32'h03E0_0008; step();
        br_type = 4'd9; jr_target = 32'h0000_3080; stall = 1; if_instr = 32'h2222_0000; #1;
        chk("jr_taken", {31'h0, taken}, 32'h1);
        step();
        chk("stall1_pc",    pc,       32'h0000_3104);
        chk("stall1_instr", id_instr, 32'h03E0_0008);
        chk("stall1_cnt",   {16'h0, taken_cnt}, 32'h3);
        jr_target = 32'h0000_3090; step();
        chk("stall2_pc",    pc,       32'h0000_3104);
        chk("stall2_id_pc", id_pc,    32'h0000_3100);
        chk("stall2_cnt",   {16'h0, taken_cnt}, 32'h3);
        stall = 0; step();
        chk("jr_pc",    pc,       32'h0000_3090);
        chk("jr_instr", id_instr, 32'h2222_0000);
        chk("jr_cnt",   {16'h0, taken_cnt}, 32'h4);

        // jr to the top of memory, then bltz with +0x7FFF words wraps around
        jr_target = 32'hFFFF_FFF0; step();
        chk("jrtop_pc", pc, 32'hFFFF_FFF0);
        br_type = 4'd0; if_instr = 32'h0400_7FFF; step();
        chk("bltz_id_pc", id_pc, 32'hFFFF_FFF0);
        br_type = 4'd5; validbgez = 1; if_instr = 32'h0; #1;
        chk("bltz_nt_taken", {31'h0, taken}, 32'h0);
        br_type = 4'd12; validbeq = 1; validbne = 1; validblez = 1;
        validbgtz = 1; validbltz = 1; #1;
        chk("type12_taken", {31'h0, taken}, 32'h0);
        br_type = 4'd5; clr_flags(); validbltz = 1; #1;
        chk("bltz_taken", {31'h0, taken}, 32'h1);
        step();
        chk("bltz_pc",  pc, 32'h0001_FFF0);
        chk("bltz_cnt", {16'h0, taken_cnt}, 32'h6);
        chk("sat6_cnt", {29'h0, s_taken_cnt}, 32'h6);

        // Reset asserted between edges while a redirect is pending
        br_type = 4'd7; clr_flags(); #1;
        chk("prerst_taken", {31'h0, taken}, 32'h1);
        #1 reset = 1'b1; br_type = 4'd0;
        #1;
        chk("mrst_pc",    pc,       32'h0000_3000);
        chk("mrst_instr", id_instr, 32'h0);
        chk("mrst_cnt",   {16'h0, taken_cnt}, 32'h0);
        #1 reset = 1'b0;
        step();
        chk("postrst_pc",  pc, 32'h0000_3004);
        chk("postrst_cnt", {16'h0, taken_cnt}, 32'h0);

        // Saturation on the 3-bit instance
        br_type = 4'd9; jr_target = 32'h0000_3000;
        for (int i = 0; i < 7; i++) step();
        chk("sat7_cnt", {29'h0, s_taken_cnt}, 32'h7);
        step();
        chk("sat8_cnt",  {29'h0, s_taken_cnt}, 32'h7);
        chk("full8_cnt", {16'h0, taken_cnt},   32'h8);
        chk("sat_pc",    pc, 32'h0000_3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/npc_fetch_ctrl.md
Name: npc_fetch_ctrl

Overview:
- Fetch-side consumer of the ID-stage branch comparator flags: owns the PC register and the IF/ID pipeline register.
- Each cycle it either holds under stall or advances, selecting the next PC from sequential, conditional branch, J/JAL or JR/JALR targets.
- MIPS delay-slot semantics: no flush; the instruction after a branch always executes.
- Sits between instruction memory, the ID-stage decoder/comparator and the hazard unit.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
CNT_W, 16, width of the taken-branch statistics counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
if_instr  input  32  instruction word read from IM at address pc
br_type  input  4  ID-stage control: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 j, 8 jal, 9 jr, 10 jalr; 11-15 treated as none
validbeq  input  1  comparator: rs==rt
validbne  input  1  comparator: rs!=rt
validblez  input  1  comparator: signed rs<=0
validbgtz  input  1  comparator: signed rs>0
validbltz  input  1  comparator: signed rs<0
validbgez  input  1  comparator: signed rs>=0
jr_target  input  32  forwarded rs value for jr/jalr
pc  output  32  current fetch address to IM
id_instr  output  32  IF/ID instruction register
id_pc  output  32  PC of the instruction in ID
id_pc8  output  32  id_pc+8, link value for jal/jalr
taken  output  1  combinational: ID-stage control transfer redirects next PC this cycle
taken_cnt  output  CNT_W  number of committed redirects, saturating

Behaviour:
- Reset (async, active-high): pc=PC_RESET; id_instr=0 (nop); id_pc=PC_RESET; taken_cnt=0. Reset mid-operation discards any pending redirect; first fetch after deassert is at PC_RESET.
- Combinational target computation:
  - br_tgt = id_pc + 4 + (sign_extend(id_instr[15:0]) << 2).
  - j_tgt = {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.
  - jr_tgt = jr_target. Bits [1:0] pass unmodified; misalignment is not checked here.
  - All adds are 32-bit, wrap modulo 2^32, no overflow trap.
- taken:
  - type 1-6: the matching valid flag.
  - type 7-10: 1.
  - otherwise: 0.
- next_pc: br_tgt if taken and type 1-6; j_tgt for 7-8; jr_tgt for 9-10; else pc+4.
- Rising edge, stall=0: pc<=next_pc; id_instr<=if_instr; id_pc<=pc; taken_cnt increments if taken and not saturated (holds at all-ones).
- Rising edge, stall=1: pc, id_instr, id_pc and taken_cnt all hold.
  - The ID instruction is re-evaluated next cycle with updated flags/jr_target.
  - A taken branch under stall is therefore counted and applied exactly once, on the first non-stalled cycle.
- Delay slot: the instruction at branch_pc+4 is in IF while the branch is in ID. It is latched into IF/ID normally; the redirect affects only the fetch after it.
- Branch in a delay slot: architecturally undefined. The block simply applies the second redirect; no special handling.
- id_pc8 = id_pc + 8, combinational.
- Latency: the redirect decision is made in ID; the target is fetched one cycle later (1-cycle delay slot, zero bubble).

Test Plan:
- Reset, then 3 cycles no stall, br_type=0 -> pc 0x3000, 0x3004, 0x3008, 0x300C; id_pc trails pc by one cycle; taken_cnt=0.
- beq at id_pc=0x3010, imm=0xFFFC, validbeq=1 -> taken=1; next pc=0x3004; the delay-slot instr from 0x3014 reaches ID; taken_cnt=1. Same with validbeq=0 -> pc=0x3018, taken_cnt unchanged.
- jal at id_pc=0x3020 with index 0x0000C40 -> pc=0x0000_3100; id_pc8=0x3028.
- jr with jr_target=0x3080 and stall=1 for 2 cycles, jr_target changing to 0x3090 on the last stall cycle -> pc, id_instr and taken_cnt frozen during stall; on release pc=0x3090 and taken_cnt increments once.
- bltz with id_instr imm=0x7FFF at id_pc=0xFFFF_FFF0, validbltz=1 -> pc wraps to 0x0001_FFF0 (mod 2^32).
- Assert reset mid-redirect (taken=1, between edges) -> pc=0x3000 immediately, id_instr=0, taken_cnt=0; the redirect is not applied after release. Force taken_cnt to all-ones, then take a branch -> count stays all-ones.
